detect_filter: RTL

DETECT_FILTER -- requirements
Module: detect_filter

---
 rtl/detect_filter_pkg.sv | 29 ++
 rtl/detect_filter_seq_div20.sv | 53 +++++
 rtl/detect_filter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/detect_filter_pkg.sv
// Shared definitions for the glove-tracking path: FSM encoding,
// default video resolution and small arithmetic helpers.
package detect_filter_pkg;

  // Default active video geometry (also used by the VGA and cursor path)
  localparam int DEF_H_RES      = 640;
  localparam int DEF_V_RES      = 480;
  localparam int DEF_AVG_LOG2   = 2;
  localparam int DEF_MISS_LIMIT = 8;
  localparam int DEF_JUMP_MAX   = 64;

  // Consecutive rejects tolerated before a far sample is forced in
  localparam int REJECT_FORCE = 2;

  // Position-filter FSM encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DIVIDE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

  // Absolute difference of two unsigned 11-bit coordinates
  function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/detect_filter_seq_div20.sv
// Sequential restoring divider: 20-bit dividend by 11-bit divisor,
// one quotient bit per clock. done pulses one cycle after the 20th step.
module seq_div20 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [19:0] dividend,
  input  logic [10:0] divisor,
  output logic        done,
  output logic [19:0] quotient,
  output logic [10:0] remainder
);

  logic [4:0]  count;
  logic        running;
  logic [11:0] partial;

  // Shift the next dividend bit into the partial remainder
  assign partial = {remainder, quotient[19]};

  // Iterate the restoring division; the quotient register doubles as the dividend shifter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= 5'd0;
      running   <= 1'b0;
      done      <= 1'b0;
      quotient  <= 20'd0;
      remainder <= 11'd0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quotient  <= dividend;
        remainder <= 11'd0;
        count     <= 5'd20;
        running   <= 1'b1;
      end else if (running) begin
        if (partial >= {1'b0, divisor}) begin
          remainder <= 11'(partial - {1'b0, divisor});
          quotient  <= {quotient[18:0], 1'b1};
        end else begin
          remainder <= partial[10:0];
          quotient  <= {quotient[18:0], 1'b0};
        end
        count <= count - 5'd1;
        if (count == 5'd1) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/detect_filter.sv
// Per-frame glove position filter: converts the detected linear pixel
// address to (col,row), rejects implausible jumps, smooths with a
// moving average and drops the track after repeated misses.
module detect_filter
  import detect_filter_pkg::*;
#(
  parameter int H_RES      = DEF_H_RES,
  parameter int V_RES      = DEF_V_RES,
  parameter int AVG_LOG2   = DEF_AVG_LOG2,
  parameter int MISS_LIMIT = DEF_MISS_LIMIT,
  parameter int JUMP_MAX   = DEF_JUMP_MAX
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vsync,
  input  logic [19:0] detect_pos_pixel,
  input  logic        achou,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        pos_valid,
  output logic        upd,
  output logic        busy,
  output logic        overrun
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 11 + AVG_LOG2;
  localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int MW    = $clog2(MISS_LIMIT + 1);
  localparam logic [19:0] FRAME_PIX = 20'(H_RES * V_RES);

  state_t         state;
  logic           vs_meta, vs_sync, vs_prev;
  logic           frame_event;
  logic           sample_ok;
  logic           div_start, div_done;
  logic [19:0]    div_quo;
  logic [10:0]    div_rem;
  logic [10:0]    col, row;
  logic [MW-1:0]  miss_cnt;
  logic [1:0]     rej_cnt;
  logic           is_miss, accept, refill, hist_empty;
  logic [PW-1:0]  ptr;
  logic [SW-1:0]  sum_x, sum_y;
  logic [10:0]    hist_x [DEPTH];
  logic [10:0]    hist_y [DEPTH];
  logic [10:0]    dx, dy;
  logic           jump;

  // Two-flop synchroniser plus edge history for the asynchronous vsync
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= vsync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign frame_event = vs_sync & ~vs_prev;
  assign sample_ok   = achou && (detect_pos_pixel < FRAME_PIX);
  assign div_start   = (state == ST_IDLE) && frame_event && sample_ok;
  assign busy        = (state != ST_IDLE);

  seq_div20 u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start),
    .dividend  (detect_pos_pixel),
    .divisor   (11'(H_RES)),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Plausibility test of the new sample against the current output
  always_comb begin
    dx   = abs_diff(col, x);
    dy   = abs_diff(row, y);
    jump = pos_valid && ((dx > 11'(JUMP_MAX)) || (dy > 11'(JUMP_MAX)));
  end

  // Filter FSM: capture, divide, plausibility check, history update, output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      x          <= 11'd0;
      y          <= 11'd0;
      pos_valid  <= 1'b0;
      upd        <= 1'b0;
      overrun    <= 1'b0;
      col        <= 11'd0;
      row        <= 11'd0;
      miss_cnt   <= '0;
      rej_cnt    <= 2'd0;
      is_miss    <= 1'b0;
      accept     <= 1'b0;
      refill     <= 1'b0;
      hist_empty <= 1'b1;
      ptr        <= '0;
      sum_x      <= '0;
      sum_y      <= '0;
    end else begin
      upd <= 1'b0;
      if (frame_event && (state != ST_IDLE))
        overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (frame_event) begin
            if (sample_ok) begin
              miss_cnt <= '0;
              is_miss  <= 1'b0;
              state    <= ST_DIVIDE;
            end else begin
              if (miss_cnt != MW'(MISS_LIMIT))
                miss_cnt <= miss_cnt + MW'(1);
              is_miss <= 1'b1;
              state   <= ST_OUT;
            end
          end
        end
        ST_DIVIDE: begin
          if (div_done) begin
            col   <= div_rem;
            // Quotient beyond 11 bits cannot occur for in-range addresses; clamp defensively
            row   <= (|div_quo[19:11]) ? 11'h7FF : div_quo[10:0];
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (jump) begin
            if (rej_cnt == 2'(REJECT_FORCE)) begin
              accept  <= 1'b1;
              refill  <= 1'b1;
              rej_cnt <= 2'd0;
            end else begin
              accept  <= 1'b0;
              refill  <= 1'b0;
              rej_cnt <= rej_cnt + 2'd1;
            end
          end else begin
            accept  <= 1'b1;
            refill  <= hist_empty;
            rej_cnt <= 2'd0;
          end
          state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          if (accept) begin
            hist_empty <= 1'b0;
            if (refill) begin
              sum_x <= SW'(col) << AVG_LOG2;
              sum_y <= SW'(row) << AVG_LOG2;
              ptr   <= '0;
            end else begin
              sum_x <= sum_x + SW'(col) - SW'(hist_x[ptr]);
              sum_y <= sum_y + SW'(row) - SW'(hist_y[ptr]);
              ptr   <= ptr + PW'(1);
            end
          end
          state <= ST_OUT;
        end
        ST_OUT: begin
          upd <= 1'b1;
          if (is_miss) begin
            if (miss_cnt == MW'(MISS_LIMIT)) begin
              pos_valid  <= 1'b0;
              hist_empty <= 1'b1;
            end
          end else if (accept) begin
            x         <= 11'(sum_x >> AVG_LOG2);
            y         <= 11'(sum_y >> AVG_LOG2);
            pos_valid <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // History buffer: all entries on re-fill, otherwise only the oldest entry
  always_ff @(posedge clk) begin
    if ((state == ST_UPDATE) && accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (refill || (ptr == PW'(i))) begin
          hist_x[i] <= col;
          hist_y[i] <= row;
        end
      end
    end
  end

endmodule
